// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter onto a single downstream OCP-style bus.
// One transaction outstanding at a time: grant in IDLE, issue in CMD, collect response in RESP.
module bus_arbiter #(
  parameter int unsigned WRITE_RESP = 1,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32
) (
  input  logic                   clk,
  input  logic                   reset,

  // requester 0
  input  logic [2:0]             in0_mcmd_i,
  input  logic [AddrWidth-1:0]   in0_maddr_i,
  input  logic [DataWidth-1:0]   in0_mdata_i,
  input  logic [DataWidth/8-1:0] in0_mbyteen_i,
  input  logic                   in0_mrespaccept_i,
  output logic                   in0_scmdaccept_o,
  output logic [1:0]             in0_sresp_o,
  output logic [DataWidth-1:0]   in0_sdata_o,

  // requester 1
  input  logic [2:0]             in1_mcmd_i,
  input  logic [AddrWidth-1:0]   in1_maddr_i,
  input  logic [DataWidth-1:0]   in1_mdata_i,
  input  logic [DataWidth/8-1:0] in1_mbyteen_i,
  input  logic                   in1_mrespaccept_i,
  output logic                   in1_scmdaccept_o,
  output logic [1:0]             in1_sresp_o,
  output logic [DataWidth-1:0]   in1_sdata_o,

  // shared downstream bus
  output logic [2:0]             out_mcmd_o,
  output logic [AddrWidth-1:0]   out_maddr_o,
  output logic [DataWidth-1:0]   out_mdata_o,
  output logic [DataWidth/8-1:0] out_mbyteen_o,
  output logic                   out_mrespaccept_o,
  output logic                   out_mreset_n_o,
  input  logic                   out_scmdaccept_i,
  input  logic [1:0]             out_sresp_i,
  input  logic [DataWidth-1:0]   out_sdata_i
);

  localparam int unsigned BeWidth = DataWidth / 8;

  localparam logic [2:0] CmdIdle  = 3'd0;
  localparam logic [2:0] CmdRd    = 3'd2;
  localparam logic [1:0] RespNull = 2'd0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmd  = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;  // index of the requester owning the bus
  logic   last_q, last_d;    // index granted most recently

  logic                 req0, req1, pick;
  logic [2:0]           gnt_mcmd;
  logic [AddrWidth-1:0] gnt_maddr;
  logic [DataWidth-1:0] gnt_mdata;
  logic [BeWidth-1:0]   gnt_mbyteen;
  logic                 gnt_mrespaccept;

  // Responses destined for the granted requester, demuxed below.
  logic                 gnt_scmdaccept;
  logic [1:0]           gnt_sresp;
  logic [DataWidth-1:0] gnt_sdata;

  assign req0 = (in0_mcmd_i != CmdIdle);
  assign req1 = (in1_mcmd_i != CmdIdle);

  // On a tie the requester not granted last wins; otherwise whoever asks.
  assign pick = (req0 && req1) ? ~last_q : req1;

  assign gnt_mcmd        = grant_q ? in1_mcmd_i        : in0_mcmd_i;
  assign gnt_maddr       = grant_q ? in1_maddr_i       : in0_maddr_i;
  assign gnt_mdata       = grant_q ? in1_mdata_i       : in0_mdata_i;
  assign gnt_mbyteen     = grant_q ? in1_mbyteen_i     : in0_mbyteen_i;
  assign gnt_mrespaccept = grant_q ? in1_mrespaccept_i : in0_mrespaccept_i;

  assign out_mreset_n_o = ~reset;

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    out_mcmd_o        = CmdIdle;
    out_maddr_o       = '0;
    out_mdata_o       = '0;
    out_mbyteen_o     = '0;
    out_mrespaccept_o = 1'b0;
    gnt_scmdaccept    = 1'b0;
    gnt_sresp         = RespNull;
    gnt_sdata         = '0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d = pick;
          last_d  = pick;
          state_d = StCmd;
        end
      end

      StCmd: begin
        if (gnt_mcmd == CmdIdle) begin
          // Requester withdrew before acceptance: abandon without issuing.
          state_d = StIdle;
        end else begin
          out_mcmd_o     = gnt_mcmd;
          out_maddr_o    = gnt_maddr;
          out_mdata_o    = gnt_mdata;
          out_mbyteen_o  = gnt_mbyteen;
          gnt_scmdaccept = out_scmdaccept_i;
          if (out_scmdaccept_i) begin
            if (gnt_mcmd == CmdRd || WRITE_RESP != 0) begin
              state_d = StResp;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end

      StResp: begin
        out_mrespaccept_o = gnt_mrespaccept;
        gnt_sresp         = out_sresp_i;
        gnt_sdata         = out_sdata_i;
        if (out_sresp_i != RespNull && gnt_mrespaccept) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    in0_scmdaccept_o = 1'b0;
    in0_sresp_o      = RespNull;
    in0_sdata_o      = '0;
    in1_scmdaccept_o = 1'b0;
    in1_sresp_o      = RespNull;
    in1_sdata_o      = '0;
    if (grant_q) begin
      in1_scmdaccept_o = gnt_scmdaccept;
      in1_sresp_o      = gnt_sresp;
      in1_sdata_o      = gnt_sdata;
    end else begin
      in0_scmdaccept_o = gnt_scmdaccept;
      in0_sresp_o      = gnt_sresp;
      in0_sdata_o      = gnt_sdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios on two instances (write response on/off)
// followed by randomized traffic scored against a transaction-level model.
module tb_bus_arbiter;

  localparam logic [2:0] CmdIdle  = 3'd0;
  localparam logic [2:0] CmdWr    = 3'd1;
  localparam logic [2:0] CmdRd    = 3'd2;
  localparam logic [1:0] RespNull = 2'd0;
  localparam logic [1:0] RespDva  = 2'd1;
  localparam logic [1:0] RespErr  = 2'd3;

  logic clk = 1'b0;
  logic reset;

  logic [2:0]  in0_mcmd, in1_mcmd;
  logic [31:0] in0_maddr, in1_maddr, in0_mdata, in1_mdata;
  logic [3:0]  in0_mbyteen, in1_mbyteen;
  logic        in0_mrespaccept, in1_mrespaccept;
  logic        out_scmdaccept;
  logic [1:0]  out_sresp;
  logic [31:0] out_sdata;

  logic        in0_scmdaccept, in1_scmdaccept;
  logic [1:0]  in0_sresp, in1_sresp;
  logic [31:0] in0_sdata, in1_sdata;
  logic [2:0]  out_mcmd;
  logic [31:0] out_maddr, out_mdata;
  logic [3:0]  out_mbyteen;
  logic        out_mrespaccept, out_mreset_n;

  logic        b_in0_scmdaccept, b_in1_scmdaccept;
  logic [1:0]  b_in0_sresp, b_in1_sresp;
  logic [31:0] b_in0_sdata, b_in1_sdata;
  logic [2:0]  b_out_mcmd;
  logic [31:0] b_out_maddr, b_out_mdata;
  logic [3:0]  b_out_mbyteen;
  logic        b_out_mrespaccept, b_out_mreset_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.WRITE_RESP(1)) dut_a (
    .clk(clk), .reset(reset),
    .in0_mcmd_i(in0_mcmd), .in0_maddr_i(in0_maddr), .in0_mdata_i(in0_mdata),
    .in0_mbyteen_i(in0_mbyteen), .in0_mrespaccept_i(in0_mrespaccept),
    .in0_scmdaccept_o(in0_scmdaccept), .in0_sresp_o(in0_sresp), .in0_sdata_o(in0_sdata),
    .in1_mcmd_i(in1_mcmd), .in1_maddr_i(in1_maddr), .in1_mdata_i(in1_mdata),
    .in1_mbyteen_i(in1_mbyteen), .in1_mrespaccept_i(in1_mrespaccept),
    .in1_scmdaccept_o(in1_scmdaccept), .in1_sresp_o(in1_sresp), .in1_sdata_o(in1_sdata),
    .out_mcmd_o(out_mcmd), .out_maddr_o(out_maddr), .out_mdata_o(out_mdata),
    .out_mbyteen_o(out_mbyteen), .out_mrespaccept_o(out_mrespaccept),
    .out_mreset_n_o(out_mreset_n), .out_scmdaccept_i(out_scmdaccept),
    .out_sresp_i(out_sresp), .out_sdata_i(out_sdata)
  );

  bus_arbiter #(.WRITE_RESP(0)) dut_b (
    .clk(clk), .reset(reset),
    .in0_mcmd_i(in0_mcmd), .in0_maddr_i(in0_maddr), .in0_mdata_i(in0_mdata),
    .in0_mbyteen_i(in0_mbyteen), .in0_mrespaccept_i(in0_mrespaccept),
    .in0_scmdaccept_o(b_in0_scmdaccept), .in0_sresp_o(b_in0_sresp), .in0_sdata_o(b_in0_sdata),
    .in1_mcmd_i(in1_mcmd), .in1_maddr_i(in1_maddr), .in1_mdata_i(in1_mdata),
    .in1_mbyteen_i(in1_mbyteen), .in1_mrespaccept_i(in1_mrespaccept),
    .in1_scmdaccept_o(b_in1_scmdaccept), .in1_sresp_o(b_in1_sresp), .in1_sdata_o(b_in1_sdata),
    .out_mcmd_o(b_out_mcmd), .out_maddr_o(b_out_maddr), .out_mdata_o(b_out_mdata),
    .out_mbyteen_o(b_out_mbyteen), .out_mrespaccept_o(b_out_mrespaccept),
    .out_mreset_n_o(b_out_mreset_n), .out_scmdaccept_i(out_scmdaccept),
    .out_sresp_i(out_sresp), .out_sdata_i(out_sdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in0_mcmd = CmdIdle; in0_maddr = '0; in0_mdata = '0; in0_mbyteen = '0; in0_mrespaccept = 0;
    in1_mcmd = CmdIdle; in1_maddr = '0; in1_mdata = '0; in1_mbyteen = '0; in1_mrespaccept = 0;
    out_scmdaccept = 0; out_sresp = RespNull; out_sdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    in0_mcmd = CmdRd; in0_maddr = 32'h44;
    step();
    #1;
    checks++;
    if (out_mreset_n !== 1'b0 || b_out_mreset_n !== 1'b0) begin
      errors++; $display("FAIL reset_mreset_n got %b/%b exp 0/0", out_mreset_n, b_out_mreset_n);
    end
    checks++;
    if (out_mcmd !== CmdIdle || out_maddr !== 0 || in0_scmdaccept !== 0 || in0_sresp !== RespNull)
    begin
      errors++; $display("FAIL reset_outputs mcmd=%0d addr=%h acc=%b resp=%0d exp idle/0/0/0",
                         out_mcmd, out_maddr, in0_scmdaccept, in0_sresp);
    end
    step();
    reset = 1'b0;
    in0_mcmd = CmdIdle;
    #1;
    checks++;
    if (out_mreset_n !== 1'b1) begin
      errors++; $display("FAIL release_mreset_n got %b exp 1", out_mreset_n);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    in0_mcmd = CmdRd; in0_maddr = 32'h10;
    #1;
    checks++;
    if (out_mcmd !== CmdIdle) begin
      errors++; $display("FAIL rd_cycle0 mcmd got %0d exp 0", out_mcmd);
    end
    step();
    out_scmdaccept = 1;
    #1;
    checks++;
    if (out_mcmd !== CmdRd || out_maddr !== 32'h10 || in0_scmdaccept !== 1'b1) begin
      errors++; $display("FAIL rd_issue mcmd=%0d addr=%h acc=%b exp 2/10/1",
                         out_mcmd, out_maddr, in0_scmdaccept);
    end
    step();
    in0_mcmd = CmdIdle; out_scmdaccept = 0;
    out_sresp = RespDva; out_sdata = 32'hA5; in0_mrespaccept = 1;
    #1;
    checks++;
    if (in0_sresp !== RespDva || in0_sdata !== 32'hA5 || out_mrespaccept !== 1'b1 ||
        in1_sresp !== RespNull || out_mcmd !== CmdIdle) begin
      errors++; $display("FAIL rd_resp resp=%0d data=%h racc=%b in1resp=%0d exp 1/a5/1/0",
                         in0_sresp, in0_sdata, out_mrespaccept, in1_sresp);
    end
    step();
    out_sresp = RespNull; out_sdata = '0; in0_mrespaccept = 0;
    in0_mcmd = CmdRd; in0_maddr = 32'h20;
    #1;
    checks++;
    if (out_mcmd !== CmdIdle || in0_sresp !== RespNull) begin
      errors++; $display("FAIL rd_back_idle mcmd=%0d resp=%0d exp 0/0", out_mcmd, in0_sresp);
    end
    step();
    #1;
    checks++;
    if (out_mcmd !== CmdRd || out_maddr !== 32'h20) begin
      errors++; $display("FAIL rd_regrant mcmd=%0d addr=%h exp 2/20", out_mcmd, out_maddr);
    end
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    in0_mcmd = CmdWr; in0_maddr = 32'h100; in0_mdata = 32'h1; in0_mbyteen = 4'hF;
    in1_mcmd = CmdWr; in1_maddr = 32'h200; in1_mdata = 32'h2; in1_mbyteen = 4'hF;
    step();
    out_scmdaccept = 1;
    #1;
    checks++;
    if (out_maddr !== 32'h100 || in0_scmdaccept !== 1'b1 || in1_scmdaccept !== 1'b0) begin
      errors++; $display("FAIL tie1_in0 addr=%h acc0=%b acc1=%b exp 100/1/0",
                         out_maddr, in0_scmdaccept, in1_scmdaccept);
    end
    step();
    in0_mcmd = CmdIdle; out_scmdaccept = 0; out_sresp = RespDva; in0_mrespaccept = 1;
    #1;
    checks++;
    if (in0_sresp !== RespDva || in1_sresp !== RespNull || out_mcmd !== CmdIdle) begin
      errors++; $display("FAIL tie1_wresp resp0=%0d resp1=%0d mcmd=%0d exp 1/0/0",
                         in0_sresp, in1_sresp, out_mcmd);
    end
    step();
    out_sresp = RespNull; in0_mrespaccept = 0;
    #1;
    checks++;
    if (out_mcmd !== CmdIdle) begin
      errors++; $display("FAIL tie1_gap mcmd got %0d exp 0", out_mcmd);
    end
    step();
    out_scmdaccept = 1;
    #1;
    checks++;
    if (out_mcmd !== CmdWr || out_maddr !== 32'h200 || out_mdata !== 32'h2) begin
      errors++; $display("FAIL tie1_in1_next mcmd=%0d addr=%h data=%h exp 1/200/2",
                         out_mcmd, out_maddr, out_mdata);
    end
    step();
    in1_mcmd = CmdIdle; out_scmdaccept = 0; out_sresp = RespDva; in1_mrespaccept = 1;
    #1;
    checks++;
    if (in1_sresp !== RespDva || in0_sresp !== RespNull) begin
      errors++; $display("FAIL tie1_in1_resp resp1=%0d resp0=%0d exp 1/0", in1_sresp, in0_sresp);
    end
    step();
    out_sresp = RespNull; in1_mrespaccept = 0;
    in0_mcmd = CmdWr; in1_mcmd = CmdWr;
    step();
    #1;
    checks++;
    if (out_maddr !== 32'h100) begin
      errors++; $display("FAIL tie2_in0 addr got %h exp 100", out_maddr);
    end
  endtask

  task automatic test_no_write_resp();
    do_reset();
    in1_mcmd = CmdWr; in1_maddr = 32'h40; in1_mdata = 32'h1234; in1_mbyteen = 4'h3;
    in1_mrespaccept = 1;
    step();
    for (int c = 1; c <= 4; c++) begin
      out_scmdaccept = (c == 4);
      #1;
      checks++;
      if (b_out_mcmd !== CmdWr || b_out_mdata !== 32'h1234 || b_out_mbyteen !== 4'h3 ||
          b_in1_scmdaccept !== (c == 4)) begin
        errors++; $display("FAIL nwr_hold c%0d mcmd=%0d data=%h be=%h acc=%b exp 1/1234/3",
                           c, b_out_mcmd, b_out_mdata, b_out_mbyteen, b_in1_scmdaccept);
      end
      step();
    end
    in1_mcmd = CmdIdle; out_scmdaccept = 0;
    in0_mcmd = CmdRd; in0_maddr = 32'hA0;
    #1;
    checks++;
    if (b_out_mcmd !== CmdIdle || b_out_mrespaccept !== 1'b0) begin
      errors++; $display("FAIL nwr_idle mcmd=%0d racc=%b exp 0/0", b_out_mcmd, b_out_mrespaccept);
    end
    step();
    #1;
    checks++;
    if (b_out_mcmd !== CmdRd || b_out_maddr !== 32'hA0) begin
      errors++; $display("FAIL nwr_no_resp_state mcmd=%0d addr=%h exp 2/a0",
                         b_out_mcmd, b_out_maddr);
    end
  endtask

  task automatic test_err_backpressure();
    do_reset();
    in0_mcmd = CmdRd; in0_maddr = 32'h30;
    step();
    out_scmdaccept = 1;
    in1_mcmd = CmdRd; in1_maddr = 32'h31;
    step();
    in0_mcmd = CmdIdle; out_scmdaccept = 0; out_sresp = RespErr; out_sdata = 32'hDEAD;
    for (int c = 0; c < 3; c++) begin
      in0_mrespaccept = (c == 2);
      #1;
      checks++;
      if (in0_sresp !== RespErr || in0_sdata !== 32'hDEAD || out_mrespaccept !== (c == 2) ||
          in1_sresp !== RespNull || in1_sdata !== 0 || out_mcmd !== CmdIdle) begin
        errors++; $display("FAIL err_hold c%0d resp0=%0d racc=%b resp1=%0d mcmd=%0d",
                           c, in0_sresp, out_mrespaccept, in1_sresp, out_mcmd);
      end
      step();
    end
    out_sresp = RespNull; in0_mrespaccept = 0;
    #1;
    checks++;
    if (out_mcmd !== CmdIdle) begin
      errors++; $display("FAIL err_after_idle mcmd got %0d exp 0", out_mcmd);
    end
    step();
    #1;
    checks++;
    if (out_mcmd !== CmdRd || out_maddr !== 32'h31) begin
      errors++; $display("FAIL err_then_in1 mcmd=%0d addr=%h exp 2/31", out_mcmd, out_maddr);
    end
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    in0_mcmd = CmdRd; in0_maddr = 32'h50;
    step();
    out_scmdaccept = 1;
    step();
    in0_mcmd = CmdIdle; out_scmdaccept = 0; out_sresp = RespDva; out_sdata = 32'h77;
    reset = 1'b1;
    #1;
    checks++;
    if (out_mreset_n !== 1'b0) begin
      errors++; $display("FAIL rst_resp_mreset_n got %b exp 0", out_mreset_n);
    end
    step();
    reset = 1'b0;
    in0_mcmd = CmdRd; in1_mcmd = CmdRd; in1_maddr = 32'h60; in0_mrespaccept = 1;
    #1;
    checks++;
    if (out_mcmd !== CmdIdle || in0_sresp !== RespNull || in1_sresp !== RespNull ||
        in0_sdata !== 0 || out_mrespaccept !== 1'b0 || out_mreset_n !== 1'b1) begin
      errors++; $display("FAIL rst_resp_abandon mcmd=%0d r0=%0d r1=%0d racc=%b exp 0/0/0/0",
                         out_mcmd, in0_sresp, in1_sresp, out_mrespaccept);
    end
    step();
    out_sresp = RespNull;
    #1;
    checks++;
    if (out_maddr !== 32'h50) begin
      errors++; $display("FAIL rst_resp_ptr addr got %h exp 50", out_maddr);
    end
  endtask

  task automatic test_hold();
    do_reset();
    in0_mcmd = CmdWr; in0_maddr = 32'h70;
    in1_mcmd = CmdRd; in1_maddr = 32'h80;
    step();
    for (int c = 1; c <= 5; c++) begin
      out_scmdaccept = (c == 3);
      if (c == 4) in0_mcmd = CmdIdle;
      out_sresp = (c == 5) ? RespDva : RespNull;
      out_sdata = 32'hCAFE;
      in0_mrespaccept = (c == 5);
      #1;
      checks++;
      if (in1_scmdaccept !== 1'b0 || in1_sresp !== RespNull || in1_sdata !== 0) begin
        errors++; $display("FAIL hold_in1 c%0d acc=%b resp=%0d data=%h exp 0/0/0",
                           c, in1_scmdaccept, in1_sresp, in1_sdata);
      end
      step();
    end
    out_sresp = RespNull; in0_mrespaccept = 0; out_scmdaccept = 0;
    #1;
    checks++;
    if (out_mcmd !== CmdIdle) begin
      errors++; $display("FAIL hold_gap mcmd got %0d exp 0", out_mcmd);
    end
    step();
    #1;
    checks++;
    if (out_mcmd !== CmdRd || out_maddr !== 32'h80) begin
      errors++; $display("FAIL hold_in1_next mcmd=%0d addr=%h exp 2/80", out_mcmd, out_maddr);
    end
  endtask

  task automatic test_violation();
    do_reset();
    in0_mcmd = CmdRd; in0_maddr = 32'h90;
    step();
    in0_mcmd = CmdIdle;
    #1;
    checks++;
    if (out_mcmd !== CmdIdle || out_maddr !== 0) begin
      errors++; $display("FAIL viol_no_issue mcmd=%0d addr=%h exp 0/0", out_mcmd, out_maddr);
    end
    step();
    in0_mcmd = CmdWr; in1_mcmd = CmdWr; in1_maddr = 32'h91;
    #1;
    checks++;
    if (out_mcmd !== CmdIdle) begin
      errors++; $display("FAIL viol_idle mcmd got %0d exp 0", out_mcmd);
    end
    step();
    #1;
    checks++;
    if (out_maddr !== 32'h91) begin
      errors++; $display("FAIL viol_ptr addr got %h exp 91", out_maddr);
    end
  endtask

  // Transaction-level model: requesters own one pending op each; the bus is either
  // free or owned; a free bus hands off on the next edge by the round-robin rule.
  task automatic test_random();
    int          phase [2];  // 0 none, 1 requesting, 2 awaiting response
    logic [2:0]  r_cmd [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_data [2];
    logic        r_racc [2];
    logic        g_acc [2];
    logic [1:0]  g_resp [2];
    logic [31:0] g_data [2];
    int          seq, owner, last, s_delay, o;
    bit          free, have_owner, expect_start, prev_busy, busy, s_pending, s_driving;
    logic [1:0]  s_resp;
    logic [31:0] s_data;
    do_reset();
    phase[0] = 0; phase[1] = 0;
    seq = 0; owner = 0; last = 1; s_delay = 0;
    free = 1; have_owner = 0; expect_start = 0; prev_busy = 0;
    s_pending = 0; s_driving = 0; s_resp = RespNull; s_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (phase[r] == 0 && $urandom_range(0, 2) == 0) begin
          phase[r] = 1;
          r_cmd[r] = ($urandom_range(0, 1) == 1) ? CmdRd : CmdWr;
          r_addr[r] = {r[3:0], seq[27:0]};
          r_data[r] = $urandom;
          seq++;
        end
        r_racc[r] = ($urandom_range(0, 1) == 1);
      end
      in0_mcmd = (phase[0] == 1) ? r_cmd[0] : CmdIdle;
      in0_maddr = r_addr[0]; in0_mdata = r_data[0]; in0_mbyteen = 4'hF;
      in0_mrespaccept = r_racc[0];
      in1_mcmd = (phase[1] == 1) ? r_cmd[1] : CmdIdle;
      in1_maddr = r_addr[1]; in1_mdata = r_data[1]; in1_mbyteen = 4'hF;
      in1_mrespaccept = r_racc[1];
      if (s_pending && !s_driving) begin
        if (s_delay == 0) begin
          s_driving = 1;
          s_resp = ($urandom_range(0, 1) == 1) ? RespDva : RespErr;
          s_data = $urandom;
        end else begin
          s_delay--;
        end
      end
      out_sresp = s_driving ? s_resp : RespNull;
      out_sdata = s_driving ? s_data : $urandom;
      out_scmdaccept = ($urandom_range(0, 1) == 1);
      #1;
      g_acc[0] = in0_scmdaccept; g_resp[0] = in0_sresp; g_data[0] = in0_sdata;
      g_acc[1] = in1_scmdaccept; g_resp[1] = in1_sresp; g_data[1] = in1_sdata;
      busy = (out_mcmd !== CmdIdle);
      o = owner;

      if (expect_start || busy) begin
        checks++;
        if (!busy || !have_owner || phase[o] != 1 || (!expect_start && !prev_busy) ||
            out_mcmd !== r_cmd[o] || out_maddr !== r_addr[o] || out_mdata !== r_data[o]) begin
          errors++; $display("FAIL rnd_issue cyc%0d mcmd=%0d addr=%h exp owner %0d cmd %0d addr %h",
                             cyc, out_mcmd, out_maddr, o, r_cmd[o], r_addr[o]);
        end
      end else begin
        checks++;
        if (out_maddr !== 0 || out_mdata !== 0 || out_mbyteen !== 0) begin
          errors++; $display("FAIL rnd_idle_bus cyc%0d addr=%h data=%h be=%h exp 0",
                             cyc, out_maddr, out_mdata, out_mbyteen);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (!have_owner || r != o) begin
          checks++;
          if (g_acc[r] !== 1'b0 || g_resp[r] !== RespNull || g_data[r] !== 0) begin
            errors++; $display("FAIL rnd_nongranted cyc%0d in%0d acc=%b resp=%0d data=%h",
                               cyc, r, g_acc[r], g_resp[r], g_data[r]);
          end
        end
      end
      if (have_owner && phase[o] == 1 && busy) begin
        checks++;
        if (g_acc[o] !== out_scmdaccept) begin
          errors++; $display("FAIL rnd_accept cyc%0d got %b exp %b", cyc, g_acc[o], out_scmdaccept);
        end
      end
      if (have_owner && phase[o] == 2) begin
        checks++;
        if (g_resp[o] !== (s_driving ? s_resp : RespNull) ||
            g_data[o] !== (s_driving ? s_data : out_sdata) || out_mrespaccept !== r_racc[o]) begin
          errors++; $display("FAIL rnd_resp cyc%0d resp=%0d data=%h racc=%b exp %0d %h %b",
                             cyc, g_resp[o], g_data[o], out_mrespaccept, s_resp, s_data, r_racc[o]);
        end
      end else begin
        checks++;
        if (out_mrespaccept !== 1'b0) begin
          errors++; $display("FAIL rnd_racc_idle cyc%0d got %b exp 0", cyc, out_mrespaccept);
        end
      end

      prev_busy = busy;
      expect_start = 0;
      if (free) begin
        if (phase[0] == 1 || phase[1] == 1) begin
          if (phase[0] == 1 && phase[1] == 1) owner = 1 - last;
          else owner = (phase[1] == 1) ? 1 : 0;
          last = owner;
          have_owner = 1;
          expect_start = 1;
          free = 0;
        end
      end else if (have_owner && phase[o] == 1 && out_scmdaccept) begin
        phase[o] = 2;
        s_pending = 1;
        s_delay = $urandom_range(0, 2);
      end else if (have_owner && phase[o] == 2 && s_driving && r_racc[o]) begin
        phase[o] = 0;
        s_pending = 0;
        s_driving = 0;
        have_owner = 0;
        free = 1;
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_single_read();
    test_tie_round_robin();
    test_no_write_resp();
    test_err_backpressure();
    test_reset_in_resp();
    test_hold();
    test_violation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WRITE_RESP, default 1, meaning: 1 = writes complete on SResp; 0 = writes complete on SCmdAccept.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in0  Bus_if.slave  -  requester 0 (MCmd/MAddr/MData/MByteEn/MRespAccept in; SCmdAccept/SResp/SData out).
REQ-005 in1  Bus_if.slave  -  requester 1, same signal set as in0.
REQ-006 out  Bus_if.master  -  shared downstream bus driven toward a single slave.

Function
REQ-007 A requester requests when its MCmd != Bus::IDLE; at most one transaction is outstanding on out at any time.
REQ-008 FSM states: IDLE, CMD, RESP; reset state is IDLE.
REQ-009 IDLE: if any request is present, register grant and go to CMD next cycle; otherwise stay in IDLE.
REQ-010 Single request: grant that requester; simultaneous requests: grant the requester not granted last (round robin).
REQ-011 Last-granted pointer resets to 1, so in0 wins the first tie after reset.
REQ-012 CMD: out.MCmd/MAddr/MData/MByteEn combinationally forward the granted requester; granted SCmdAccept = out.SCmdAccept.
REQ-013 CMD exit when out.SCmdAccept=1: RD, or WR with WRITE_RESP=1 -> RESP; WR with WRITE_RESP=0 -> IDLE.
REQ-014 RESP: out.MCmd = Bus::IDLE; granted SResp/SData = out.SResp/out.SData; out.MRespAccept = granted MRespAccept.
REQ-015 RESP exit when out.SResp != NULL and out.MRespAccept=1 (DVA and ERR both complete) -> IDLE.
REQ-016 Grant latency: request in IDLE at cycle n appears on out.MCmd at cycle n+1; minimum of 2 cycles between back-to-back grants (the IDLE cycle is mandatory).
REQ-017 Outside CMD: out.MCmd = Bus::IDLE, and out.MAddr/MData/MByteEn = 0.
REQ-018 Non-granted requester, or any requester in IDLE: SCmdAccept=0, SResp=NULL, SData=0.
REQ-019 The granted requester is held for the whole transaction; a competing request waits with no timeout and no pre-emption.
REQ-020 If the granted requester drops MCmd to IDLE while in CMD (protocol violation), the FSM returns to IDLE without issuing; the pointer is still updated.
REQ-021 out.MReset_n = ~reset.

Reset
REQ-022 While reset=1 on a clock edge: FSM->IDLE, pointer->1, grant cleared; all outputs take their REQ-017/018 values from the following cycle.
REQ-023 Reset asserted in CMD or RESP abandons the transaction: no response is forwarded and no state is retained.
REQ-024 out.MReset_n is 0 exactly while reset=1.

Verification
REQ-025 After reset, in0 RD addr 0x10 alone, slave accepts at once and returns DVA data 0xA5 one cycle later -> out.MCmd=RD at cycle 1, in0.SResp=DVA with SData=0xA5, FSM back in IDLE.
REQ-026 in0 and in1 both WR in the same cycle after reset -> in0 granted first, in1 granted immediately after the IDLE cycle that follows in0 completion; a second tie is granted to in0 again.
REQ-027 WRITE_RESP=0, in1 WR data 0x1234 byteen 0x3, SCmdAccept held low 3 cycles -> MCmd/MData/MByteEn stable for 4 cycles, return to IDLE on the accept with no RESP state.
REQ-028 RD answered with ERR while MRespAccept=0 for 2 cycles -> FSM stays in RESP, and completes in the cycle MRespAccept=1; in1 sees SResp=NULL throughout.
REQ-029 reset pulsed during RESP -> next cycle out.MCmd=IDLE, both SResp=NULL, pointer=1, and the next tie is won by in0.
REQ-030 in1 requests continuously while in0 holds the grant for 5 cycles -> in1 sees SCmdAccept=0 and SResp=NULL for those cycles and is granted next.
